// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave round-robin bus arbiter.
//
// Master 0 (Core) and master 1 (loader/DMA) share one slave bus. One
// transaction is granted at a time. Ties go to the master that was not
// granted last. The slave response and read data are routed back only to
// the owning master.
//
// Optional feature: define BUS_TIMEOUT_EN to enable a watchdog. It
// terminates a transaction after TIMEOUT_CYCLES BUSY cycles without an
// s_response, and pulses bus_error when it does. Without the macro,
// bus_error is tied low and BUSY waits indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles before forced termination (>= 2, watchdog only)
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   mX_read, mX_write                  master request strobes (held until response)
//   mX_option, mX_address, mX_write_data  master access code, address, store data
//   mX_read_data, mX_response          routed slave data / completion pulse
//   s_read, s_write, s_option,
//   s_address, s_write_data            owner's signals to the slave decoder
//   s_read_data, s_response            slave data and completion pulse
//   bus_error                          one-cycle pulse on watchdog termination
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [2:0]  m0_option,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  output logic [31:0] m0_read_data,
  output logic        m0_response,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [2:0]  m1_option,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  output logic [31:0] m1_read_data,
  output logic        m1_response,
  output logic        s_read,
  output logic        s_write,
  output logic [2:0]  s_option,
  output logic [31:0] s_address,
  output logic [31:0] s_write_data,
  input  logic [31:0] s_read_data,
  input  logic        s_response,
  output logic        bus_error
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   last_grant, last_grant_nxt;
  logic   m0_req, m1_req;
  logic   timeout;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;

  // Holding the counter at zero throughout IDLE is equivalent to clearing
  // it on entry to BUSY, and keeps the update a single expression.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!s_response) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A genuine response in the final cycle takes precedence over the watchdog.
  assign timeout = (state == BUSY) && !s_response &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt = BUSY;
          if (m0_req && m1_req) begin
            owner_nxt = ~last_grant;
          end else begin
            owner_nxt = m1_req;
          end
        end
      end
      BUSY: begin
        if (s_response || timeout) begin
          state_nxt      = IDLE;
          last_grant_nxt = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: everything is zero in IDLE; in BUSY the owner's request
  // is muxed to the slave and the slave's answer back to the owner only.
  always_comb begin
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_option     = '0;
    s_address    = '0;
    s_write_data = '0;
    m0_response  = 1'b0;
    m0_read_data = '0;
    m1_response  = 1'b0;
    m1_read_data = '0;
    bus_error    = 1'b0;
    if (state == BUSY) begin
      bus_error = timeout;
      if (owner) begin
        s_read       = m1_read;
        s_write      = m1_write;
        s_option     = m1_option;
        s_address    = m1_address;
        s_write_data = m1_write_data;
        m1_response  = s_response | timeout;
        m1_read_data = timeout ? '0 : s_read_data;
      end else begin
        s_read       = m0_read;
        s_write      = m0_write;
        s_option     = m0_option;
        s_address    = m0_address;
        s_write_data = m0_write_data;
        m0_response  = s_response | timeout;
        m0_read_data = timeout ? '0 : s_read_data;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter. Stimulus pushes master commands plus
// the expected grant and response sequences; a monitor compares whenever
// the slave strobes start a new transaction or a master response appears.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [2:0]  m0_option, m1_option, s_option;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_response, m1_response;
  logic        s_read, s_write;
  logic [31:0] s_address, s_write_data, s_read_data;
  logic        s_response, bus_error;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_option(m0_option),
    .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_read_data(m0_read_data), .m0_response(m0_response),
    .m1_read(m1_read), .m1_write(m1_write), .m1_option(m1_option),
    .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_read_data(m1_read_data), .m1_response(m1_response),
    .s_read(s_read), .s_write(s_write), .s_option(s_option),
    .s_address(s_address), .s_write_data(s_write_data),
    .s_read_data(s_read_data), .s_response(s_response),
    .bus_error(bus_error)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  opt;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int   m;
    cmd_t c;
    int   lat;   // cycles from request to first strobe (0 = not checked)
    int   gap;   // cycles from previous response to strobe (0 = not checked)
  } grant_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        err;
    int          busy_n;  // BUSY cycle index of the response (0 = not checked)
  } resp_t;

  cmd_t   mq [2][$];
  grant_t eg [$];
  resp_t  er [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_cyc [2];
  int g_cyc = 0;
  int r_cyc = 0;
  int tb_owner = 0;
  logic in_busy = 1'b0;
  logic [1:0] active = 2'b00;

  int          slave_lat = 2;
  logic [31:0] slave_data = '0;

  logic [1:0]  rd = 2'b00, wr = 2'b00;
  logic [2:0]  opt [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [1:0]  resp_v;

  assign m0_read = rd[0];  assign m0_write = wr[0];
  assign m0_option = opt[0];  assign m0_address = addr[0];  assign m0_write_data = wdat[0];
  assign m1_read = rd[1];  assign m1_write = wr[1];
  assign m1_option = opt[1];  assign m1_address = addr[1];  assign m1_write_data = wdat[1];
  assign resp_v = {m1_response, m0_response};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model: answers in BUSY cycle slave_lat (0 = never), presenting
  // slave_data for the whole transaction.
  initial begin
    int cnt;
    cnt = 0;
    s_response = 1'b0;
    s_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (s_read || s_write) begin
        cnt++;
        s_read_data = slave_data;
        s_response = (slave_lat != 0) && (cnt == slave_lat);
      end else begin
        cnt = 0;
        s_read_data = '0;
        s_response = 1'b0;
      end
    end
  end

  // Master drivers: hold the request until the response, drop it for the
  // following cycle; a reset abandons the transaction.
  for (genvar g = 0; g < 2; g++) begin : g_drv
    initial begin
      cmd_t c;
      bit got, ab;
      opt[g] = '0; addr[g] = '0; wdat[g] = '0;
      forever begin
        while (mq[g].size() == 0) @(posedge clk);
        @(posedge clk);
        #1;
        c = mq[g].pop_front();
        rd[g] = !c.wr; wr[g] = c.wr; opt[g] = c.opt; addr[g] = c.addr; wdat[g] = c.wdata;
        req_cyc[g] = cyc;
        active[g] = 1'b1;
        got = 0;
        ab = 0;
        for (int n = 0; n < 64 && !got && !ab; n++) begin
          @(negedge clk);
          if (reset) ab = 1;
          else if (resp_v[g]) got = 1;
        end
        if (!got && !ab) begin
          checks++;
          errors++;
          $display("FAIL m%0d_response_wait: no response within 64 cycles, required one", g);
        end
        if (got) begin
          @(posedge clk);
          #1;
        end
        rd[g] = 1'b0; wr[g] = 1'b0; opt[g] = '0; addr[g] = '0; wdat[g] = '0;
        active[g] = 1'b0;
      end
    end
  end

  // Monitor: grant and response scoreboard plus non-owner quietness.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      in_busy = 1'b0;
    end else begin
      if ((s_read || s_write) && !in_busy) begin
        if (eg.size() == 0) begin
          check("unexpected_grant", s_address, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          grant_t gx;
          gx = eg.pop_front();
          check("grant_address", s_address, gx.c.addr);
          check("grant_write_data", s_write_data, gx.c.wdata);
          check("grant_option", s_option, gx.c.opt);
          check("grant_strobes", {s_read, s_write}, {!gx.c.wr, gx.c.wr});
          if (gx.lat != 0) check("req_to_strobe", cyc - req_cyc[gx.m], gx.lat);
          if (gx.gap != 0) check("resp_to_grant", cyc - r_cyc, gx.gap);
          tb_owner = gx.m;
          g_cyc = cyc;
        end
      end
      in_busy = s_read || s_write;
      if (!(in_busy && tb_owner == 0)) check("m0_quiet", {m0_response, m0_read_data}, 0);
      if (!(in_busy && tb_owner == 1)) check("m1_quiet", {m1_response, m1_read_data}, 0);
      if (m0_response || m1_response || bus_error) begin
        if (er.size() == 0) begin
          check("unexpected_response", {bus_error, m1_response, m0_response}, 0);
        end else begin
          resp_t rx;
          rx = er.pop_front();
          check("resp_master", {m1_response, m0_response}, (rx.m == 0) ? 2'b01 : 2'b10);
          check("resp_data", (rx.m == 0) ? m0_read_data : m1_read_data, rx.data);
          check("bus_error", bus_error, rx.err);
          if (rx.busy_n != 0) check("resp_busy_cycle", cyc - g_cyc + 1, rx.busy_n);
        end
        r_cyc = cyc;
      end
    end
  end

  function automatic cmd_t mk(input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.wr = w; c.opt = o; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic grant_t gr(input int m, input cmd_t c, input int lat, input int gap);
    grant_t gx;
    gx.m = m; gx.c = c; gx.lat = lat; gx.gap = gap;
    return gx;
  endfunction

  function automatic resp_t rs(input int m, input logic [31:0] d, input logic e, input int b);
    resp_t rx;
    rx.m = m; rx.data = d; rx.err = e; rx.busy_n = b;
    return rx;
  endfunction

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = (mq[0].size() == 0) && (mq[1].size() == 0) && (eg.size() == 0) &&
             (er.size() == 0) && (active == 2'b00) && !in_busy;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: outstanding work after 300 cycles, required none", name);
    end
  endtask

  initial begin
    cmd_t ca, cb, cc, cd;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", |{s_read, s_write, s_option, s_address, s_write_data,
                             m0_read_data, m0_response, m1_read_data, m1_response, bus_error}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Contention from reset: m0 wins the first tie, then strict alternation.
    slave_lat = 3;
    slave_data = 32'h0000_1111;
    ca = mk(0, 3'b010, 32'h0000_0A00, 32'h0);
    cb = mk(1, 3'b000, 32'h0000_0B00, 32'h0000_00B1);
    cc = mk(0, 3'b001, 32'h0000_0A04, 32'h0);
    cd = mk(1, 3'b101, 32'h0000_0B04, 32'h0000_00B2);
    eg.push_back(gr(0, ca, 1, 0));
    eg.push_back(gr(1, cb, 0, 2));
    eg.push_back(gr(0, cc, 0, 2));
    eg.push_back(gr(1, cd, 0, 2));
    for (int i = 0; i < 4; i++) er.push_back(rs(i % 2, 32'h0000_1111, 1'b0, 3));
    mq[0].push_back(ca); mq[0].push_back(cc);
    mq[1].push_back(cb); mq[1].push_back(cd);
    wait_idle("contention");

    // Single read by m0 answered in the 4th BUSY cycle.
    slave_lat = 4;
    slave_data = 32'h1234_5678;
    ca = mk(0, 3'b010, 32'h0000_0010, 32'h0);
    eg.push_back(gr(0, ca, 1, 0));
    er.push_back(rs(0, 32'h1234_5678, 1'b0, 4));
    mq[0].push_back(ca);
    wait_idle("single_read");

    // Reset in the 2nd BUSY cycle aborts silently; the next tie goes to m0.
    slave_lat = 0;
    slave_data = 32'h5555_AAAA;
    ca = mk(0, 3'b010, 32'h0000_0400, 32'h0);
    eg.push_back(gr(0, ca, 1, 0));
    mq[0].push_back(ca);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_read) break;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_quiet", |{s_read, s_write, s_option, s_address, s_write_data,
                           m0_response, m1_response}, 0);
    slave_lat = 2;
    slave_data = 32'h0000_2222;
    ca = mk(0, 3'b010, 32'h0000_0500, 32'h0);
    cb = mk(0, 3'b010, 32'h0000_0600, 32'h0);
    eg.push_back(gr(0, ca, 1, 0));
    eg.push_back(gr(1, cb, 0, 2));
    er.push_back(rs(0, 32'h0000_2222, 1'b0, 2));
    er.push_back(rs(1, 32'h0000_2222, 1'b0, 2));
    mq[0].push_back(ca);
    mq[1].push_back(cb);
    wait_idle("post_reset_tie");

    // m1 requests while m0 is BUSY and is granted after one IDLE cycle.
    slave_lat = 4;
    slave_data = 32'h0000_3333;
    ca = mk(1, 3'b010, 32'h0000_0100, 32'h1111_1111);
    cb = mk(1, 3'b010, 32'h0000_0200, 32'hCAFE_BABE);
    eg.push_back(gr(0, ca, 1, 0));
    eg.push_back(gr(1, cb, 0, 2));
    er.push_back(rs(0, 32'h0000_3333, 1'b0, 4));
    er.push_back(rs(1, 32'h0000_3333, 1'b0, 4));
    mq[0].push_back(ca);
    repeat (2) @(posedge clk);
    mq[1].push_back(cb);
    wait_idle("hold_busy");

`ifdef BUS_TIMEOUT_EN
    // Silent slave: each owner is terminated in its 8th BUSY cycle.
    slave_lat = 0;
    slave_data = 32'hDEAD_BEEF;
    ca = mk(0, 3'b010, 32'h0000_0300, 32'h0);
    cb = mk(0, 3'b010, 32'h0000_0304, 32'h0);
    eg.push_back(gr(0, ca, 1, 0));
    eg.push_back(gr(1, cb, 0, 2));
    er.push_back(rs(0, 32'h0, 1'b1, 8));
    er.push_back(rs(1, 32'h0, 1'b1, 8));
    mq[0].push_back(ca);
    repeat (2) @(posedge clk);
    mq[1].push_back(cb);
    wait_idle("timeout");

    // Response coinciding with the timeout cycle wins.
    slave_lat = 8;
    slave_data = 32'hA5A5_A5A5;
    ca = mk(0, 3'b010, 32'h0000_0700, 32'h0);
    eg.push_back(gr(0, ca, 1, 0));
    er.push_back(rs(0, 32'hA5A5_A5A5, 1'b0, 8));
    mq[0].push_back(ca);
    wait_idle("timeout_coincide");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
